// File: rtl/serial_add_pkg.sv
// serial_add_pkg: shared FSM state type and default width
// for the bit-serial adder controller.
package serial_add_pkg;

   localparam int SERIAL_ADD_WIDTH_DEFAULT = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/serial_add_fa_cell.sv
// serial_add_fa_cell: single-bit full adder, purely combinational.
// Ports: x, y, ci in; s (sum bit), co (carry out) out.
module serial_add_fa_cell (
   input  logic x,
   input  logic y,
   input  logic ci,
   output logic s,
   output logic co
);

   assign s  = x ^ y ^ ci;
   assign co = (x & y) | (ci & (x ^ y));

endmodule

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial A+B+cin, LSB first, one cell per clock.
// Ports: clk, rst (sync, high), start, a, b, cin in; busy, done, sum,
// cout out; ovf out only when SERIAL_ADD_OVF_EN is defined.
module serial_add_ctrl
   import serial_add_pkg::*;
#(
   parameter int WIDTH = SERIAL_ADD_WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
`ifdef SERIAL_ADD_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t           state;
   logic [WIDTH-1:0] opa;
   logic [WIDTH-1:0] opb;
   logic [WIDTH-1:0] res;
   logic             carry;
   logic [CW-1:0]    cnt;
   logic             cs;
   logic             cc;

   serial_add_fa_cell u_cell (
      .x  (opa[0]),
      .y  (opb[0]),
      .ci (carry),
      .s  (cs),
      .co (cc)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         opa   <= '0;
         opb   <= '0;
         res   <= '0;
         carry <= 1'b0;
         cnt   <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
         sum   <= '0;
         cout  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
         ovf   <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  opa   <= a;
                  opb   <= b;
                  carry <= cin;
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= RUN;
               end
            end
            RUN: begin
               opa   <= opa >> 1;
               opb   <= opb >> 1;
               res   <= {cs, res[WIDTH-1:1]};
               carry <= cc;
               if (cnt == LAST) begin
                  sum   <= {cs, res[WIDTH-1:1]};
                  cout  <= cc;
`ifdef SERIAL_ADD_OVF_EN
                  // carry reg holds the carry into the MSB here
                  ovf   <= carry ^ cc;
`endif
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= DONE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: directed table-driven bench, WIDTH=8.
// Ovf checks are active when SERIAL_ADD_OVF_EN is defined.
module tb_serial_add_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [7:0] a;
   logic [7:0] b;
   logic       cin;
   logic       busy;
   logic       done;
   logic [7:0] sum;
   logic       cout;
`ifdef SERIAL_ADD_OVF_EN
   logic       ovf;
`endif

   int n_chk  = 0;
   int n_fail = 0;
   logic [7:0] prev_sum;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       cin;
      logic [7:0] s;
      logic       co;
      logic       ov;
   } vec_t;

   vec_t vt[9];

   always #5 clk = ~clk;

   serial_add_ctrl #(.WIDTH(8)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .cin   (cin),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout)
`ifdef SERIAL_ADD_OVF_EN
      ,
      .ovf   (ovf)
`endif
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic do_op(input vec_t v);
      int lat;
      int bcnt;
      start = 1'b1;
      a     = v.a;
      b     = v.b;
      cin   = v.cin;
      tick();
      start = 1'b0;
      a     = ~v.a;
      b     = v.b ^ 8'h5A;
      cin   = ~v.cin;
      chk("busy_acc", 32'(busy), 32'd1);
      chk("sum_hold", 32'(sum), 32'(prev_sum));
      lat  = 0;
      bcnt = 0;
      while (!done && lat < 30) begin
         if (busy) bcnt++;
         tick();
         lat++;
      end
      chk("latency", 32'(lat), 32'd8);
      chk("busy_cnt", 32'(bcnt), 32'd8);
      chk("busy_done", 32'(busy), 32'd0);
      chk("sum", 32'(sum), 32'(v.s));
      chk("cout", 32'(cout), 32'(v.co));
`ifdef SERIAL_ADD_OVF_EN
      chk("ovf", 32'(ovf), 32'(v.ov));
`endif
      prev_sum = v.s;
      tick();
      chk("done_pulse", 32'(done), 32'd0);
      chk("sum_keep", 32'(sum), 32'(v.s));
   endtask

   initial begin
      int lat;
      int seen;
      vt[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1};
      vt[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
      vt[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
      vt[3] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
      vt[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
      vt[5] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0};
      vt[6] = '{8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0, 1'b0};
      vt[7] = '{8'h80, 8'h7F, 1'b1, 8'h00, 1'b1, 1'b0};
      vt[8] = '{8'h64, 8'h64, 1'b0, 8'hC8, 1'b0, 1'b1};

      rst   = 1'b1;
      start = 1'b1;
      a     = 8'hFF;
      b     = 8'hFF;
      cin   = 1'b1;
      tick();
      tick();
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_sum", 32'(sum), 32'd0);
      chk("rst_cout", 32'(cout), 32'd0);
`ifdef SERIAL_ADD_OVF_EN
      chk("rst_ovf", 32'(ovf), 32'd0);
`endif
      start    = 1'b0;
      rst      = 1'b0;
      prev_sum = 8'h00;
      tick();
      chk("idle_busy", 32'(busy), 32'd0);

      for (int i = 0; i < 9; i++) do_op(vt[i]);

      // start held high: operands changed mid-run, one done per 10 cycles
      start = 1'b1;
      a     = 8'h12;
      b     = 8'h34;
      cin   = 1'b0;
      tick();
      a   = 8'hFF;
      b   = 8'hFF;
      cin = 1'b1;
      lat = 0;
      while (!done && lat < 30) begin
         tick();
         lat++;
      end
      chk("hold_lat", 32'(lat), 32'd8);
      chk("hold_sum", 32'(sum), 32'h46);
      chk("hold_cout", 32'(cout), 32'd0);
      a   = 8'h01;
      b   = 8'h02;
      cin = 1'b0;
      tick();
      chk("hold_idle_busy", 32'(busy), 32'd0);
      chk("hold_idle_done", 32'(done), 32'd0);
      tick();
      a   = 8'hFF;
      b   = 8'hFF;
      cin = 1'b1;
      lat = 2;
      while (!done && lat < 30) begin
         tick();
         lat++;
      end
      chk("hold_period", 32'(lat), 32'd10);
      chk("hold_sum2", 32'(sum), 32'h03);
      start = 1'b0;
      tick();
      tick();
      prev_sum = 8'h03;

      // reset in the 4th RUN cycle aborts the operation
      start = 1'b1;
      a     = 8'h5A;
      b     = 8'h3C;
      cin   = 1'b0;
      tick();
      start = 1'b0;
      tick();
      tick();
      tick();
      chk("abort_busy_pre", 32'(busy), 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      chk("abort_sum", 32'(sum), 32'd0);
      chk("abort_cout", 32'(cout), 32'd0);
      seen = 0;
      for (int i = 0; i < 12; i++) begin
         if (done) seen++;
         tick();
      end
      chk("abort_nodone", 32'(seen), 32'd0);
      prev_sum = 8'h00;
      do_op(vt[0]);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 Parameter WIDTH, default 8, operand and result width in bits; legal range 2..32.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 start  input  1  request an addition; sampled only in IDLE.
REQ-005 a  input  WIDTH  operand A; captured on the accepting edge.
REQ-006 b  input  WIDTH  operand B; captured on the accepting edge.
REQ-007 cin  input  1  carry-in; captured on the accepting edge.
REQ-008 busy  output  1  high while in RUN.
REQ-009 done  output  1  one-cycle pulse when the result is valid.
REQ-010 sum  output  WIDTH  registered result.
REQ-011 cout  output  1  registered carry-out.

Function
REQ-012 The block SHALL sequence one single-bit full-adder cell, LSB first, to add A+B+cin bit-serially.
REQ-013 FSM states SHALL be IDLE, RUN and DONE, with no other reachable states.
REQ-014 IDLE with start=1: on that edge, latch a, b and cin into shift and carry registers, clear the bit counter to 0, and go to RUN.
REQ-015 IDLE with start=0: remain in IDLE, with no register change.
REQ-016 RUN, per edge: compute cell sum and carry from the operand LSBs and the carry register, shift the sum bit into the result register at the MSB end, shift the operands right, update carry, and increment the counter.
REQ-017 RUN, on the edge processing bit WIDTH-1: copy the result register to sum and the final carry to cout, then go to DONE.
REQ-018 Latency: done SHALL be high in the cycle after the WIDTH-th edge following the accepting edge, exactly WIDTH cycles after acceptance.
REQ-019 DONE: done=1 and busy=0 for exactly one cycle, then unconditionally go to IDLE.
REQ-020 start in RUN or DONE SHALL be ignored, with no queuing; a new request is accepted no earlier than the first IDLE cycle after done.
REQ-021 sum and cout SHALL change only on the DONE-entry edge and on reset, and hold their value otherwise, including through a new RUN.
REQ-022 Changes on a, b and cin after the accepting edge SHALL have no effect on the result in progress.
REQ-023 Arithmetic: unsigned, modulo 2^WIDTH; cout is bit WIDTH of A+B+cin.
REQ-024 The counter SHALL be ceil(log2(WIDTH)) bits wide and SHALL NOT wrap within one operation.

Reset
REQ-025 rst=1 at an edge SHALL force IDLE, and clear busy, done, sum, cout, the carry, counter, operand and result registers to 0.
REQ-026 rst=1 in RUN or DONE SHALL abort the operation; no done pulse for that operation.
REQ-027 rst has priority over start on the same edge.

Configuration
REQ-028 Macro SERIAL_ADD_OVF_EN defined: add output ovf (1 bit), the two's-complement overflow, equal to the carry into bit WIDTH-1 XOR cout.
REQ-029 ovf SHALL be registered with sum, held with the same rules, and reset to 0.
REQ-030 Macro undefined: no ovf port and no related logic; the rest of the behaviour is identical.

Structure
REQ-031 Package serial_add_pkg SHALL hold the FSM state enum (IDLE, RUN, DONE) and the constant SERIAL_ADD_WIDTH_DEFAULT=8.
REQ-032 The single-bit cell SHALL be a separate combinational sub-module serial_add_fa_cell, with inputs x, y, ci and outputs s, co.
REQ-033 serial_add_ctrl SHALL hold all sequential logic.

Verification (WIDTH=8)
REQ-034 Basic add: a=0x5A, b=0x3C, cin=0, start pulse -> done after 8 cycles; sum=0x96, cout=0; busy high for exactly 8 cycles.
REQ-035 Carry ripple: a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; then a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
REQ-036 Start while busy: start held high throughout -> one done per 10 cycles (IDLE, 8x RUN, DONE); operand changes during RUN do not affect the result.
REQ-037 Mid-operation reset: rst in the 4th RUN cycle -> IDLE next cycle; sum=0, cout=0; no done pulse; the next start completes normally.
REQ-038 With SERIAL_ADD_OVF_EN: a=0x7F, b=0x01, cin=0 -> sum=0x80, ovf=1, cout=0; a=0x80, b=0x80 -> sum=0x00, ovf=1, cout=1.
